// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding,
// port identifiers and default timing limits.
package dmem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_MAX_WAIT = 15;
    localparam int DEFAULT_WAIT_W   = 4;

    // One-hot two-bit grant to port id; an all-zero grant maps to port 0.
    function automatic logic grant_to_port(input logic [1:0] grant);
        return grant[1] ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// the port that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port data memory between two load/store requesters with
// round-robin arbitration and one transaction in flight.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = DEFAULT_MAX_WAIT,
    parameter int WAIT_W     = DEFAULT_WAIT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  req1_err,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_ready
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [1:0]            state_q, state_d;
    logic                  port_q, port_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [1:0]            grant;
    logic                  finish;
    logic                  timeout;

    rr_arbiter2 u_arb (
        .req_i        ({req1_valid, req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_d       = wait_q;
        finish       = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    port_d       = grant_to_port(grant);
                    last_grant_d = grant_to_port(grant);
                    addr_d       = grant[1] ? req1_addr  : req0_addr;
                    wdata_d      = grant[1] ? req1_wdata : req0_wdata;
                    wait_d       = '0;
                    state_d      = (grant[1] ? req1_we : req0_we) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                finish  = 1'b1;
                state_d = ST_RESP;
            end
            ST_WRITE: begin
                // mem_ready on the first write cycle still reflects the idle memory.
                if (mem_ready && (wait_q != '0)) begin
                    finish  = 1'b1;
                    state_d = ST_RESP;
                end else if (wait_q == WAIT_LIMIT) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            port_q       <= PORT0;
            last_grant_q <= PORT1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_q       <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_q       <= wait_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PID = 1'(gi);
            logic                  done_q;
            logic                  err_q;
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end else begin
                    done_q <= finish && (port_q == PID);
                    err_q  <= timeout && (port_q == PID);
                    if ((state_q == ST_READ) && (port_q == PID)) begin
                        rdata_q <= mem_rd_data;
                    end
                end
            end
        end
    endgenerate

    assign req0_done   = g_port[0].done_q;
    assign req0_err    = g_port[0].err_q;
    assign req0_rdata  = g_port[0].rdata_q;
    assign req1_done   = g_port[1].done_q;
    assign req1_err    = g_port[1].err_q;
    assign req1_rdata  = g_port[1].rdata_q;

    assign mem_rd_en   = (state_q == ST_READ);
    assign mem_wr_en   = (state_q == ST_WRITE);
    assign mem_addr    = addr_q;
    assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word memory model whose
// ready drops during a write of configurable length.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        mem_rd_en, mem_wr_en, mem_ready;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    dmem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: ready is 1 while idle, 0 after the first write edge, 1 once wr_lat edges have passed.
    logic [31:0] mem [0:255];
    logic        init_mem = 1'b1;
    int          wk = 0;
    int          wr_lat = 6;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hCAFEF00D;
        end else if (mem_wr_en && wk == wr_lat - 1) begin
            mem[mem_addr[7:0]] <= mem_wr_data;
        end
        wk <= mem_wr_en ? wk + 1 : 0;
    end

    assign mem_ready   = (wk == 0) || (wk >= wr_lat);
    assign mem_rd_data = mem[mem_addr[7:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor on the falling edge.
    int done_cnt0 = 0, done_cnt1 = 0, dual_done = 0, en_overlap = 0;
    int log_port [$];
    int log_cyc [$];
    always @(negedge clk) begin
        if (req0_done) begin done_cnt0++; log_port.push_back(0); log_cyc.push_back(cyc); end
        if (req1_done) begin done_cnt1++; log_port.push_back(1); log_cyc.push_back(cyc); end
        if (req0_done && req1_done) dual_done++;
        if (mem_rd_en && mem_wr_en) en_overlap++;
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for port p's done; returns cycles since start.
    task automatic wait_done(input int p, input int start, input string tag, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (n < 60) begin
            step();
            n++;
            if ((p == 0 && req0_done) || (p == 1 && req1_done)) begin
                lat = cyc - start;
                break;
            end
        end
        if (lat < 0) chk({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    int t0, lat, d1;

    initial begin
        repeat (3) step();
        init_mem = 1'b0;
        chk("rst_done0", {req0_done, req1_done, req0_err, req1_err}, 4'b0);
        chk("rst_en", {mem_rd_en, mem_wr_en}, 2'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wr_data, 32'h0);
        chk("rst_rdata", {req0_rdata, req1_rdata}, 64'h0);
        reset = 1'b0;
        step();

        // 1: reset in the middle of a write from port 1.
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h60; req1_wdata = 32'h77;
        repeat (3) step();
        chk("t1_wr_active", mem_wr_en, 1'b1);
        d1 = done_cnt1;
        reset = 1'b1;
        req1_valid = 1'b0;
        step();
        chk("t1_wr_dropped", mem_wr_en, 1'b0);
        chk("t1_addr_clr", mem_addr, 32'h0);
        step(); step();
        chk("t1_no_done", done_cnt1 - d1, 0);
        reset = 1'b0;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h30;
        t0 = cyc;
        step();
        chk("t1_first_p0", {mem_rd_en, mem_addr}, {1'b1, 32'h10});
        step();
        chk("t1_p0_done", {req0_done, req1_done}, 2'b10);
        req0_valid = 1'b0;
        wait_done(1, t0, "t1_p1", lat);
        chk("t1_p1_rdata", req1_rdata, 32'hCAFEF00D);
        chk("t1_p1_lat", lat, 5);
        req1_valid = 1'b0;
        step();

        // 2: single read with exact latency.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        t0 = cyc;
        step();
        chk("t2_rd_en", {mem_rd_en, mem_wr_en, mem_addr}, {2'b10, 32'h10});
        chk("t2_not_yet", req0_done, 1'b0);
        step();
        chk("t2_done", {req0_done, req0_err}, 2'b10);
        chk("t2_rdata", req0_rdata, 32'hDEADBEEF);
        req0_valid = 1'b0;
        step();
        chk("t2_pulse_1cyc", req0_done, 1'b0);
        chk("t2_rdata_held", req0_rdata, 32'hDEADBEEF);

        // 3: write from port 1 with the 6-cycle memory, then read back on port 1.
        d1 = done_cnt1;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h12345678;
        t0 = cyc;
        step();
        chk("t3_wr_en", {mem_wr_en, mem_wr_data}, {1'b1, 32'h12345678});
        wait_done(1, t0, "t3_wr", lat);
        chk("t3_lat", lat, 8);
        chk("t3_err", req1_err, 1'b0);
        req1_valid = 1'b0;
        step(); step();
        chk("t3_done_once", done_cnt1 - d1, 1);
        chk("t3_mem", mem[8'h20], 32'h12345678);
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h20;
        t0 = cyc;
        wait_done(1, t0, "t3_rb", lat);
        chk("t3_readback", req1_rdata, 32'h12345678);
        req1_valid = 1'b0;
        step();

        // 4: both ports streaming reads; last grant was port 1.
        log_port.delete(); log_cyc.delete();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h30;
        t0 = cyc;
        repeat (12) step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(); step();
        chk("t4_count", log_port.size(), 4);
        if (log_port.size() >= 4) begin
            chk("t4_order", {log_port[0][3:0], log_port[1][3:0], log_port[2][3:0], log_port[3][3:0]}, 16'h0101);
            chk("t4_first_cyc", log_cyc[0] - t0, 2);
            chk("t4_spacing", log_cyc[3] - log_cyc[0], 9);
        end
        chk("t4_rdata", {req0_rdata, req1_rdata}, {32'hDEADBEEF, 32'hCAFEF00D});

        // 5: memory never completes -> timeout after 15 wait cycles, then a normal read.
        wr_lat = 1000;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h40; req0_wdata = 32'h55;
        t0 = cyc;
        wait_done(0, t0, "t5_wr", lat);
        chk("t5_lat", lat, 17);
        chk("t5_err", req0_err, 1'b1);
        req0_valid = 1'b0;
        step();
        chk("t5_err_pulse", req0_err, 1'b0);
        wr_lat = 6;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h10;
        t0 = cyc;
        wait_done(1, t0, "t5_next", lat);
        chk("t5_next_lat", lat, 2);
        chk("t5_next", {req1_err, req1_rdata}, {1'b0, 32'hDEADBEEF});
        req1_valid = 1'b0;
        step();

        // 6: port 0 write and port 1 read of the same address presented together.
        d1 = done_cnt1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 32'h50; req0_wdata = 32'hA5A5A5A5;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h50;
        t0 = cyc;
        wait_done(0, t0, "t6_wr", lat);
        chk("t6_wr_lat", lat, 8);
        chk("t6_p1_waiting", done_cnt1 - d1, 0);
        req0_valid = 1'b0;
        wait_done(1, t0, "t6_rd", lat);
        chk("t6_rd_lat", lat, 11);
        chk("t6_rd_new", req1_rdata, 32'hA5A5A5A5);
        req1_valid = 1'b0;
        step(); step();

        chk("never_dual_done", dual_done, 0);
        chk("en_exclusive", en_overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
